// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receiver and the future transmitter.
// Frame format: one start bit, DATA_BITS data bits sent LSB-first, one stop bit.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam int   IDX_W       = $clog2(DATA_BITS);
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input.
// The reset value is a parameter so that an idle-high line comes out of reset high.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Receive half of the lab 4 serial link: deserialises 8N1 frames into bytes
// and hands them to the processor through a level flag and an acknowledge pulse.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 serial_in,
    input  logic                 char_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 character_received,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (serial_in),
        .q     (rx_s)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state              <= IDLE;
            cnt                <= '0;
            idx                <= '0;
            shift              <= '0;
            data_out           <= '0;
            character_received <= 1'b0;
            framing_error      <= 1'b0;
            overrun_error      <= 1'b0;
        end else begin
            framing_error <= 1'b0;

            // A commit later in this block overrides the acknowledge clear.
            if (char_ack) begin
                character_received <= 1'b0;
                overrun_error      <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_TC) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= (rx_s == START_LEVEL) ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_TC) begin
                        // Leave at mid-stop-bit so a back-to-back start edge is caught.
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s == STOP_LEVEL) begin
                            data_out           <= shift;
                            character_received <= 1'b1;
                            if (character_received && !char_ack) begin
                                overrun_error <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: frames are pushed to a scoreboard with
// their expected commit cycle and checked by a monitor when that cycle arrives.
module tb_serial_receiver;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
    localparam int LAT = 3 + H + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         fe;
        bit         pre;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       char_ack;
    logic [7:0] data_out;
    logic       character_received;
    logic       framing_error;
    logic       overrun_error;

    int         checks;
    int         failures;
    int         cyc;
    int         fe_seen;
    logic [7:0] m_data;
    ent_t       sb[$];

    serial_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_clk            (clk),
        .reset_reset_n      (rst_n),
        .serial_in          (serial_in),
        .char_ack           (char_ack),
        .data_out           (data_out),
        .character_received (character_received),
        .framing_error      (framing_error),
        .overrun_error      (overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial fe_seen = 0;
    always @(negedge clk) begin
        if (framing_error === 1'b1) fe_seen++;
        if (sb.size() > 0) begin
            if (sb[0].pre && cyc == sb[0].due - 1)
                check("flag_before_latency", 32'(character_received), 32'd0);
            if (cyc == sb[0].due) begin
                ent_t e;
                e = sb.pop_front();
                if (e.fe) begin
                    check("fe_pulse", 32'(framing_error), 32'd1);
                    check("fe_data_kept", 32'(data_out), 32'(e.data));
                end else begin
                    check("commit_flag", 32'(character_received), 32'd1);
                    check("commit_data", 32'(data_out), 32'(e.data));
                end
            end
        end
    end

    // Called 1 time unit after a rising edge; returns likewise aligned.
    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input bit pre);
        ent_t e;
        e.due  = cyc + LAT;
        e.fe   = !stop_ok;
        e.pre  = pre;
        if (stop_ok) m_data = d;
        e.data = m_data;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        serial_in = 1'b1;
    endtask

    task automatic ack_pulse(input string tag);
        char_ack = 1'b1;
        @(posedge clk);
        #1 char_ack = 1'b0;
        @(negedge clk);
        check({tag, "_flag"}, 32'(character_received), 32'd0);
        check({tag, "_ovr"}, 32'(overrun_error), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_data    = 8'h00;
        rst_n     = 1'b0;
        serial_in = 1'b1;
        char_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_flag", 32'(character_received), 32'd0);
        check("rst_fe", 32'(framing_error), 32'd0);
        check("rst_ovr", 32'(overrun_error), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        check("a5_ovr", 32'(overrun_error), 32'd0);
        check("a5_no_fe", 32'(fe_seen), 32'd0);
        @(posedge clk);
        #1;
        ack_pulse("ack1");

        serial_in = 1'b0;
        repeat (H - 2) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        @(negedge clk);
        check("glitch_flag", 32'(character_received), 32'd0);
        check("glitch_data", 32'(data_out), 32'hA5);
        check("glitch_no_fe", 32'(fe_seen), 32'd0);
        @(posedge clk);
        #1;

        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        @(negedge clk);
        check("fe_flag", 32'(character_received), 32'd0);
        check("fe_data", 32'(data_out), 32'hA5);
        check("fe_one_cycle", 32'(fe_seen), 32'd1);
        @(posedge clk);
        #1;

        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'hFE, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_data", 32'(data_out), 32'hFE);
        check("b2b_flag", 32'(character_received), 32'd1);
        check("b2b_ovr", 32'(overrun_error), 32'd1);
        @(posedge clk);
        #1;
        ack_pulse("ack2");

        send_frame(8'h12, 1'b1, 1'b0);
        fork
            send_frame(8'h34, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 char_ack = 1'b1;
                @(posedge clk);
                #1 char_ack = 1'b0;
            end
        join
        @(negedge clk);
        check("ackwin_flag", 32'(character_received), 32'd1);
        check("ackwin_ovr", 32'(overrun_error), 32'd0);
        check("ackwin_data", 32'(data_out), 32'h34);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        repeat (H) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 32'h00);
        check("midrst_flag", 32'(character_received), 32'd0);
        check("midrst_fe", 32'(framing_error), 32'd0);
        check("midrst_ovr", 32'(overrun_error), 32'd0);
        serial_in = 1'b1;
        m_data    = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        @(negedge clk);
        check("postrst_flag", 32'(character_received), 32'd0);
        check("postrst_no_fe", 32'(fe_seen), 32'd1);
        @(posedge clk);
        #1;

        send_frame(8'h55, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("p55_data", 32'(data_out), 32'h55);
        check("p55_flag", 32'(character_received), 32'd1);
        check("p55_ovr", 32'(overrun_error), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
